// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD write queue
package lcd_pkg;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  typedef enum logic [1:0] {
    PWR_WAIT,
    IDLE,
    ISSUE,
    GAP
  } lcd_q_state_t;

  localparam logic [31:0] OFS_CMD  = 32'd0;
  localparam logic [31:0] OFS_DATA = 32'd1;
  localparam logic [31:0] OFS_CLR  = 32'd2;

  // HD44780: 8-bit 2-line, display on, clear, entry mode increment
  localparam int unsigned INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

endpackage

// File: rtl/lcd_write_queue_if.sv
// rtl/lcd_write_queue_if.sv - store-bus style write port (data, address, strobe)
interface lcd_write_queue_if;
  logic [31:0] DATA;
  logic [31:0] ADDR;
  logic        WRSTB;

  modport master (output DATA, ADDR, WRSTB);
  modport slave  (input  DATA, ADDR, WRSTB);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - show-ahead FIFO of LCD entries, wrap-bit pointers
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       push,
  input  lcd_entry_t wr_entry,
  input  logic       pop,
  output lcd_entry_t rd_entry,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  lcd_entry_t  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/lcd_write_queue.sv
// rtl/lcd_write_queue.sv - buffers CPU LCD writes, runs init, paces strobes
module lcd_write_queue
  import lcd_pkg::*;
#(
  parameter logic [31:0] BASEADDRESS    = 32'h5000_0000,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned GAP_CYCLES     = 100010,
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter bit          INIT_EN        = 1'b1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  lcd_write_queue_if.slave   cpu,
  lcd_write_queue_if.master  lcd,
  output logic               FULL,
  output logic               EMPTY,
  output logic               BUSY,
  output logic               OVERFLOW
);

  localparam int unsigned MAX_CYC = (GAP_CYCLES > POWERUP_CYCLES) ? GAP_CYCLES : POWERUP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC);

  lcd_q_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    init_idx;
  logic [31:0]   lcd_addr_q;
  logic [31:0]   lcd_data_q;
  logic          lcd_wrstb_q;

  logic       hit;
  logic       clr;
  logic       push;
  logic       pop;
  logic       init_pending;
  logic       work;
  logic       cnt_done;
  lcd_entry_t wr_entry;
  lcd_entry_t head;
  logic       data_unused;

  assign hit = cpu.WRSTB && ((cpu.ADDR == BASEADDRESS + OFS_CMD) ||
                             (cpu.ADDR == BASEADDRESS + OFS_DATA));
  assign clr      = cpu.WRSTB && (cpu.ADDR == BASEADDRESS + OFS_CLR);
  assign push     = hit && !FULL;
  assign wr_entry = '{rs: cpu.ADDR[0], data: cpu.DATA[7:0]};
  assign data_unused = ^cpu.DATA[31:8];

  assign init_pending = INIT_EN && (init_idx < 3'(INIT_LEN));
  assign work         = init_pending || !EMPTY;
  // Leaving on 1 rather than 0 folds the ISSUE cycle into the spacing
  assign cnt_done     = (cnt == CW'(1)) || (cnt == '0);
  assign BUSY         = init_pending || !EMPTY || (state == ISSUE) || (state == GAP);

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (FULL),
    .empty    (EMPTY)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      PWR_WAIT: if (cnt_done) state_nxt = ISSUE;
      IDLE:     if (work) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = GAP;
        pop       = !init_pending;
      end
      GAP:      if (cnt_done) state_nxt = work ? ISSUE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= INIT_EN ? PWR_WAIT : IDLE;
      cnt   <= CW'(POWERUP_CYCLES - 1);
    end else begin
      state <= state_nxt;
      if (state == ISSUE)
        cnt <= CW'(GAP_CYCLES - 1);
      else if (((state == PWR_WAIT) || (state == GAP)) && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_idx    <= '0;
      lcd_addr_q  <= '0;
      lcd_data_q  <= '0;
      lcd_wrstb_q <= 1'b0;
    end else begin
      lcd_wrstb_q <= (state == ISSUE);
      if (state == ISSUE) begin
        if (init_pending) begin
          lcd_addr_q <= BASEADDRESS + OFS_CMD;
          lcd_data_q <= {24'b0, INIT_ROM[init_idx[1:0]]};
          init_idx   <= init_idx + 1'b1;
        end else begin
          lcd_addr_q <= BASEADDRESS + {31'b0, head.rs};
          lcd_data_q <= {24'b0, head.data};
        end
      end
    end
  end

  // A dropped write outranks a clear arriving on the same cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      OVERFLOW <= 1'b0;
    else if (hit && FULL)
      OVERFLOW <= 1'b1;
    else if (clr)
      OVERFLOW <= 1'b0;
  end

  assign lcd.ADDR  = lcd_addr_q;
  assign lcd.DATA  = lcd_data_q;
  assign lcd.WRSTB = lcd_wrstb_q;

endmodule
